// File: rtl/cluster_frame_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// cluster_frame_scheduler_pkg
// Shared constants for the per-bunch-crossing cluster frame scheduler:
// default geometry, header field widths and the FSM state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package cluster_frame_scheduler_pkg;

  // Default geometry of the scheduler.
  localparam int DEF_MAX_CLUSTERS = 8;
  localparam int DEF_CNT_LATENCY  = 2;
  localparam int DEF_CNT_W        = 8;
  localparam int DEF_BX_MAX       = 3564;
  localparam int DEF_STAT_W       = 16;

  // Header field widths. BXN_W must hold BX_MAX-1.
  localparam int BXN_W = 12;

  // Scheduler FSM state encoding.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

endpackage

// File: rtl/cluster_frame_scheduler_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Statistics counter that adds a variable amount every cycle and sticks
// at all-ones instead of wrapping.
// Ports:
//   clock4x  in   clock
//   reset_n  in   asynchronous active-low reset
//   inc      in   INC_W  amount to add this cycle (0 = hold)
//   count    out  W      saturating count
// ---------------------------------------------------------------------------
module sat_counter
  import cluster_frame_scheduler_pkg::*;
#(
  parameter int W     = DEF_STAT_W,
  parameter int INC_W = 1
) (
  input  logic             clock4x,
  input  logic             reset_n,
  input  logic [INC_W-1:0] inc,
  output logic [W-1:0]     count
);

  // One extra bit beyond the wider operand so the carry out of the add is
  // visible and can be used to detect saturation.
  localparam int SUM_W = ((W > INC_W) ? W : INC_W) + 1;
  localparam logic [SUM_W-1:0] LIMIT = {{(SUM_W-W){1'b0}}, {W{1'b1}}};

  logic [SUM_W-1:0] sum;

  assign sum = SUM_W'(count) + SUM_W'(inc);

  always_ff @(posedge clock4x or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else begin
      count <= (sum > LIMIT) ? '1 : sum[W-1:0];
    end
  end

endmodule

// File: rtl/cluster_frame_scheduler.sv
// ---------------------------------------------------------------------------
// cluster_frame_scheduler
// Per-bunch-crossing scheduler behind the cluster-count tree. Tags each
// frame with its BX number, aligns the frame strobe with the pipelined
// cluster count, clamps the count to MAX_CLUSTERS, emits a frame header and
// then one slot-select per cluster over a valid/ready handshake. A single
// pending slot absorbs a frame that arrives while another is being issued.
// Ports:
//   clock4x      in   clock
//   reset_n      in   asynchronous active-low reset
//   frame_start  in   pulse: new frame's vpfs presented this cycle
//   bx0          in   with frame_start: this frame is BX 0
//   cnt          in   CNT_W cluster count, valid CNT_LATENCY cycles later
//   hdr_valid    out  one-cycle header strobe
//   hdr_ncl      out  clusters sent this frame
//   hdr_ovf      out  count exceeded MAX_CLUSTERS
//   hdr_bxn      out  frame BX number
//   sel_valid    out  slot select valid
//   sel_idx      out  cluster slot index
//   sel_last     out  final select of the frame
//   sel_ready    in   encoder accepts select
//   busy         out  FSM not idle or pending frame held
//   trunc_cnt    out  saturating count of clusters removed by clamping
//   drop_cnt     out  saturating count of dropped frames
// ---------------------------------------------------------------------------
module cluster_frame_scheduler
  import cluster_frame_scheduler_pkg::*;
#(
  parameter int MAX_CLUSTERS  = DEF_MAX_CLUSTERS,
  parameter int CNT_LATENCY   = DEF_CNT_LATENCY,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int BX_MAX        = DEF_BX_MAX,
  parameter int STAT_W        = DEF_STAT_W,
  localparam int NCL_W        = $clog2(MAX_CLUSTERS + 1),
  localparam int IDX_W        = $clog2(MAX_CLUSTERS)
) (
  input  logic              clock4x,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic              bx0,
  input  logic [CNT_W-1:0]  cnt,
  output logic              hdr_valid,
  output logic [NCL_W-1:0]  hdr_ncl,
  output logic              hdr_ovf,
  output logic [BXN_W-1:0]  hdr_bxn,
  output logic              sel_valid,
  output logic [IDX_W-1:0]  sel_idx,
  output logic              sel_last,
  input  logic              sel_ready,
  output logic              busy,
  output logic [STAT_W-1:0] trunc_cnt,
  output logic [STAT_W-1:0] drop_cnt
);

  // -------------------------------------------------------------------------
  // BX counter and frame tagging
  // -------------------------------------------------------------------------
  logic [BXN_W-1:0] bx_ctr;
  logic [BXN_W-1:0] frame_tag;

  // A bx0 frame is tagged 0 regardless of the running count, so the next
  // untagged frame must continue from 1.
  assign frame_tag = bx0 ? '0 : bx_ctr;

  always_ff @(posedge clock4x or negedge reset_n) begin
    if (!reset_n) begin
      bx_ctr <= '0;
    end else if (frame_start) begin
      if (bx0) begin
        bx_ctr <= BXN_W'(1);
      end else if (bx_ctr == BXN_W'(BX_MAX - 1)) begin
        bx_ctr <= '0;
      end else begin
        bx_ctr <= bx_ctr + BXN_W'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Alignment pipe: carries {valid, bxn} alongside the counter tree so the
  // frame arrives exactly when its cnt is valid. Back-to-back strobes each
  // occupy their own stage.
  // -------------------------------------------------------------------------
  logic             pipe_valid [CNT_LATENCY];
  logic [BXN_W-1:0] pipe_bxn   [CNT_LATENCY];

  always_ff @(posedge clock4x or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CNT_LATENCY; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_bxn[i]   <= '0;
      end
    end else begin
      pipe_valid[0] <= frame_start;
      pipe_bxn[0]   <= frame_tag;
      for (int i = 1; i < CNT_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_bxn[i]   <= pipe_bxn[i-1];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Arrival: clamp the count and work out how many clusters are discarded.
  // -------------------------------------------------------------------------
  logic             arr_valid;
  logic [BXN_W-1:0] arr_bxn;
  logic             arr_ovf;
  logic [NCL_W-1:0] arr_ncl;
  logic [CNT_W-1:0] arr_excess;

  assign arr_valid = pipe_valid[CNT_LATENCY-1];
  assign arr_bxn   = pipe_bxn[CNT_LATENCY-1];

  always_comb begin
    arr_ovf    = (cnt > CNT_W'(MAX_CLUSTERS));
    arr_ncl    = arr_ovf ? NCL_W'(MAX_CLUSTERS) : NCL_W'(cnt);
    arr_excess = arr_ovf ? (cnt - CNT_W'(MAX_CLUSTERS)) : '0;
  end

  // -------------------------------------------------------------------------
  // Launch / pending / drop decisions
  // -------------------------------------------------------------------------
  logic [0:0]       state;
  logic [NCL_W-1:0] cur_ncl;
  logic             pend_valid;
  logic [NCL_W-1:0] pend_ncl;
  logic             pend_ovf;
  logic [BXN_W-1:0] pend_bxn;

  logic             hs;
  logic             can_launch;
  logic             launch_pend;
  logic             launch_arr;
  logic             launch;
  logic             store_arr;
  logic             drop_arr;
  logic [NCL_W-1:0] src_ncl;
  logic             src_ovf;
  logic [BXN_W-1:0] src_bxn;
  logic [NCL_W-1:0] next_idx;

  assign hs = (state == ST_ISSUE) && sel_valid && sel_ready;

  // A new header can go out from IDLE, or directly behind the handshake of
  // the last select so back-to-back frames see only a one-cycle gap.
  assign can_launch  = (state == ST_IDLE) || (hs && sel_last);
  assign launch_pend = can_launch && pend_valid;
  assign launch_arr  = can_launch && !pend_valid && arr_valid;
  assign launch      = launch_pend || launch_arr;

  // An arrival not launched directly may take the pending slot if it is
  // empty or is being vacated this very cycle; otherwise it is lost.
  assign store_arr = arr_valid && !launch_arr && (!pend_valid || launch_pend);
  assign drop_arr  = arr_valid && !launch_arr && pend_valid && !launch_pend;

  assign src_ncl = launch_pend ? pend_ncl : arr_ncl;
  assign src_ovf = launch_pend ? pend_ovf : arr_ovf;
  assign src_bxn = launch_pend ? pend_bxn : arr_bxn;

  assign next_idx = NCL_W'(sel_idx) + NCL_W'(1);

  always_ff @(posedge clock4x or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid <= 1'b0;
      pend_ncl   <= '0;
      pend_ovf   <= 1'b0;
      pend_bxn   <= '0;
    end else if (store_arr) begin
      pend_valid <= 1'b1;
      pend_ncl   <= arr_ncl;
      pend_ovf   <= arr_ovf;
      pend_bxn   <= arr_bxn;
    end else if (launch_pend) begin
      pend_valid <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Header / select FSM. The first select is presented together with the
  // header; header fields hold between strobes.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock4x or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cur_ncl   <= '0;
      hdr_valid <= 1'b0;
      hdr_ncl   <= '0;
      hdr_ovf   <= 1'b0;
      hdr_bxn   <= '0;
      sel_valid <= 1'b0;
      sel_idx   <= '0;
      sel_last  <= 1'b0;
    end else begin
      hdr_valid <= 1'b0;
      if (launch) begin
        hdr_valid <= 1'b1;
        hdr_ncl   <= src_ncl;
        hdr_ovf   <= src_ovf;
        hdr_bxn   <= src_bxn;
        cur_ncl   <= src_ncl;
        sel_idx   <= '0;
        if (src_ncl == '0) begin
          state     <= ST_IDLE;
          sel_valid <= 1'b0;
          sel_last  <= 1'b0;
        end else begin
          state     <= ST_ISSUE;
          sel_valid <= 1'b1;
          sel_last  <= (src_ncl == NCL_W'(1));
        end
      end else if (hs) begin
        if (sel_last) begin
          state     <= ST_IDLE;
          sel_valid <= 1'b0;
          sel_idx   <= '0;
          sel_last  <= 1'b0;
        end else begin
          sel_idx  <= sel_idx + IDX_W'(1);
          sel_last <= (next_idx == (cur_ncl - NCL_W'(1)));
        end
      end
    end
  end

  assign busy = (state != ST_IDLE) || pend_valid;

  // -------------------------------------------------------------------------
  // Slow-control statistics. Dropped frames still contribute their excess.
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] trunc_inc;
  logic             drop_inc;

  assign trunc_inc = arr_valid ? arr_excess : '0;
  assign drop_inc  = drop_arr;

  sat_counter #(
    .W     (STAT_W),
    .INC_W (CNT_W)
  ) u_trunc_counter (
    .clock4x (clock4x),
    .reset_n (reset_n),
    .inc     (trunc_inc),
    .count   (trunc_cnt)
  );

  sat_counter #(
    .W     (STAT_W),
    .INC_W (1)
  ) u_drop_counter (
    .clock4x (clock4x),
    .reset_n (reset_n),
    .inc     (drop_inc),
    .count   (drop_cnt)
  );

endmodule

// File: tb/tb_cluster_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_cluster_frame_scheduler
// Scoreboard bench: every frame driven pushes its expected header and its
// expected select sequence; a negedge monitor pops and compares them as the
// scheduler produces headers and select handshakes.
// ---------------------------------------------------------------------------
module tb_cluster_frame_scheduler;

  localparam int MAXC = 8;
  localparam int LAT  = 2;
  localparam int CW   = 8;
  localparam int BXM  = 3564;
  localparam int SW   = 16;
  localparam int SMAX = (1 << SW) - 1;

  logic          clock4x = 1'b0;
  logic          reset_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          bx0 = 1'b0;
  logic [CW-1:0] cnt = '0;
  logic          sel_ready = 1'b0;
  logic          hdr_valid;
  logic [3:0]    hdr_ncl;
  logic          hdr_ovf;
  logic [11:0]   hdr_bxn;
  logic          sel_valid;
  logic [2:0]    sel_idx;
  logic          sel_last;
  logic          busy;
  logic [SW-1:0] trunc_cnt;
  logic [SW-1:0] drop_cnt;

  always #5 clock4x = ~clock4x;

  cluster_frame_scheduler #(
    .MAX_CLUSTERS (MAXC),
    .CNT_LATENCY  (LAT),
    .CNT_W        (CW),
    .BX_MAX       (BXM),
    .STAT_W       (SW)
  ) dut (
    .clock4x     (clock4x),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .bx0         (bx0),
    .cnt         (cnt),
    .hdr_valid   (hdr_valid),
    .hdr_ncl     (hdr_ncl),
    .hdr_ovf     (hdr_ovf),
    .hdr_bxn     (hdr_bxn),
    .sel_valid   (sel_valid),
    .sel_idx     (sel_idx),
    .sel_last    (sel_last),
    .sel_ready   (sel_ready),
    .busy        (busy),
    .trunc_cnt   (trunc_cnt),
    .drop_cnt    (drop_cnt)
  );

  typedef struct packed {
    logic [3:0]  ncl;
    logic        ovf;
    logic [11:0] bxn;
  } hdr_exp_t;

  typedef struct packed {
    logic [2:0] idx;
    logic       last;
  } sel_exp_t;

  hdr_exp_t hdr_q[$];
  sel_exp_t sel_q[$];
  hdr_exp_t mon_h;
  sel_exp_t mon_s;

  int n_compared   = 0;
  int n_mismatched = 0;
  int model_bx     = 0;
  int model_trunc  = 0;
  int model_drop   = 0;
  int dly_cnt [LAT];

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               tag, actual, expected, $time);
    end
  endtask

  // Drives one cycle of inputs. cnt for a frame is delivered LAT cycles
  // after its strobe through a small delay line; expectations for the frame
  // are pushed at strobe time unless the scenario says it must be dropped.
  task automatic applyStimulus(input bit fs, input bit b0, input int c,
                               input bit expect_drop);
    int tag;
    int ncl;
    frame_start = fs;
    bx0         = b0;
    cnt         = CW'(dly_cnt[LAT-1]);
    for (int i = LAT - 1; i > 0; i--) dly_cnt[i] = dly_cnt[i-1];
    dly_cnt[0] = fs ? c : 0;
    if (fs) begin
      if (b0) begin
        tag      = 0;
        model_bx = 1;
      end else begin
        tag      = model_bx;
        model_bx = (model_bx == BXM - 1) ? 0 : model_bx + 1;
      end
      ncl = (c > MAXC) ? MAXC : c;
      model_trunc = model_trunc + (c - ncl);
      if (model_trunc > SMAX) model_trunc = SMAX;
      if (expect_drop) begin
        model_drop = model_drop + 1;
        if (model_drop > SMAX) model_drop = SMAX;
      end else begin
        hdr_q.push_back('{ncl: 4'(ncl), ovf: (c > MAXC), bxn: 12'(tag)});
        for (int i = 0; i < ncl; i++)
          sel_q.push_back('{idx: 3'(i), last: (i == ncl - 1)});
      end
    end
    @(posedge clock4x);
    #1;
  endtask

  task automatic drain(input int limit);
    bit done;
    done      = 1'b0;
    sel_ready = 1'b1;
    for (int i = 0; i < limit && !done; i++) begin
      applyStimulus(1'b0, 1'b0, 0, 1'b0);
      if (i >= LAT + 1 && !busy && !hdr_valid &&
          hdr_q.size() == 0 && sel_q.size() == 0)
        done = 1'b1;
    end
    if (!done) checkOutput("drain_timeout", 32'(busy), 32'(0));
  endtask

  // Monitor: headers and select handshakes against the scoreboard.
  always @(negedge clock4x) begin
    if (reset_n) begin
      if (hdr_valid) begin
        if (hdr_q.size() == 0) begin
          checkOutput("hdr_unexpected", 32'(hdr_valid), 32'(0));
        end else begin
          mon_h = hdr_q.pop_front();
          checkOutput("hdr_ncl", 32'(hdr_ncl), 32'(mon_h.ncl));
          checkOutput("hdr_ovf", 32'(hdr_ovf), 32'(mon_h.ovf));
          checkOutput("hdr_bxn", 32'(hdr_bxn), 32'(mon_h.bxn));
        end
      end
      if (sel_valid) begin
        if (sel_q.size() == 0) begin
          checkOutput("sel_unexpected", 32'(sel_valid), 32'(0));
        end else begin
          mon_s = sel_q[0];
          checkOutput("sel_idx", 32'(sel_idx), 32'(mon_s.idx));
          checkOutput("sel_last", 32'(sel_last), 32'(mon_s.last));
          if (sel_ready) void'(sel_q.pop_front());
        end
      end else begin
        checkOutput("sel_idx_idle", 32'(sel_idx), 32'(0));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < LAT; i++) dly_cnt[i] = 0;

    // Reset state
    repeat (3) @(posedge clock4x);
    #1;
    checkOutput("rst_hdr_valid", 32'(hdr_valid), 32'(0));
    checkOutput("rst_hdr_ncl",   32'(hdr_ncl),   32'(0));
    checkOutput("rst_hdr_bxn",   32'(hdr_bxn),   32'(0));
    checkOutput("rst_sel_valid", 32'(sel_valid), 32'(0));
    checkOutput("rst_busy",      32'(busy),      32'(0));
    checkOutput("rst_trunc",     32'(trunc_cnt), 32'(0));
    checkOutput("rst_drop",      32'(drop_cnt),  32'(0));
    reset_n = 1'b1;
    repeat (2) applyStimulus(1'b0, 1'b0, 0, 1'b0);

    // cnt=5, idle latency and select sequence
    sel_ready = 1'b1;
    applyStimulus(1'b1, 1'b0, 5, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0, 0, 1'b0);
    checkOutput("lat_hdr_valid", 32'(hdr_valid), 32'(1));
    checkOutput("lat_sel_valid", 32'(sel_valid), 32'(1));
    checkOutput("lat_sel_idx0",  32'(sel_idx),   32'(0));
    repeat (4) applyStimulus(1'b0, 1'b0, 0, 1'b0);
    checkOutput("lat_sel_idx4",  32'(sel_idx),   32'(4));
    checkOutput("lat_sel_last",  32'(sel_last),  32'(1));
    drain(50);
    checkOutput("hold_hdr_ncl", 32'(hdr_ncl), 32'(5));

    // cnt=12 clamps to 8 with overflow
    applyStimulus(1'b1, 1'b0, 12, 1'b0);
    drain(50);
    checkOutput("trunc_after_12", 32'(trunc_cnt), 32'(4));
    checkOutput("hold_hdr_ovf",   32'(hdr_ovf),   32'(1));

    // Back-pressure at idx 2 for three cycles
    applyStimulus(1'b1, 1'b0, 5, 1'b0);
    repeat (4) applyStimulus(1'b0, 1'b0, 0, 1'b0);
    checkOutput("stall_pre_idx", 32'(sel_idx), 32'(2));
    sel_ready = 1'b0;
    repeat (3) begin
      applyStimulus(1'b0, 1'b0, 0, 1'b0);
      checkOutput("stall_valid", 32'(sel_valid), 32'(1));
      checkOutput("stall_idx",   32'(sel_idx),   32'(2));
    end
    sel_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 0, 1'b0);
    checkOutput("stall_resume_idx", 32'(sel_idx), 32'(3));
    drain(50);

    // Frames every 4 cycles, cnt=8, encoder always ready: pending absorbs
    for (int k = 0; k < 20; k++) begin
      applyStimulus(k == 0 || k == 4 || k == 8, 1'b0, 8, 1'b0);
      if (k + 1 == 3 || k + 1 == 11 || k + 1 == 19)
        checkOutput("pend_hdr_slot", 32'(hdr_valid), 32'(1));
    end
    drain(60);
    checkOutput("pend_no_drop", 32'(drop_cnt), 32'(0));

    // Same with encoder stuck: third frame dropped
    sel_ready = 1'b0;
    for (int k = 0; k < 14; k++)
      applyStimulus(k == 0 || k == 4 || k == 8, 1'b0, 8, k == 8);
    checkOutput("stuck_busy", 32'(busy),     32'(1));
    checkOutput("stuck_drop", 32'(drop_cnt), 32'(1));
    drain(60);
    checkOutput("stuck_drop_after", 32'(drop_cnt), 32'(model_drop));

    // Empty frame: header only
    applyStimulus(1'b1, 1'b0, 0, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0, 0, 1'b0);
    checkOutput("zero_hdr_valid", 32'(hdr_valid), 32'(1));
    checkOutput("zero_ncl",       32'(hdr_ncl),   32'(0));
    checkOutput("zero_sel_valid", 32'(sel_valid), 32'(0));
    applyStimulus(1'b0, 1'b0, 0, 1'b0);
    checkOutput("zero_busy",      32'(busy),      32'(0));
    checkOutput("zero_hdr_once",  32'(hdr_valid), 32'(0));
    drain(20);

    // bx0 in mid-count
    applyStimulus(1'b1, 1'b0, 1, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 0, 1'b0);
    applyStimulus(1'b1, 1'b1, 2, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1, 1'b0);
    drain(30);
    checkOutput("bx0_next_tag", 32'(hdr_bxn), 32'(1));

    // Drive trunc_cnt into saturation, then confirm it holds
    while (model_trunc < SMAX) begin
      applyStimulus(1'b1, 1'b0, 255, 1'b0);
      repeat (9) applyStimulus(1'b0, 1'b0, 0, 1'b0);
    end
    drain(60);
    checkOutput("trunc_sat", 32'(trunc_cnt), 32'(16'hFFFF));
    applyStimulus(1'b1, 1'b0, 255, 1'b0);
    drain(60);
    checkOutput("trunc_hold", 32'(trunc_cnt), 32'(16'hFFFF));

    // BX wrap: back-to-back empty frames through the modulus
    applyStimulus(1'b1, 1'b1, 0, 1'b0);
    for (int k = 1; k < BXM + 2; k++) applyStimulus(1'b1, 1'b0, 0, 1'b0);
    drain(20);
    checkOutput("bx_wrap_last", 32'(hdr_bxn), 32'(1));

    // Reset while issuing, with another frame still in the pipe
    sel_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 8, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3, 1'b0);
    checkOutput("pre_rst_sel_valid", 32'(sel_valid), 32'(1));
    #2;
    reset_n     = 1'b0;
    frame_start = 1'b0;
    cnt         = '0;
    #1;
    checkOutput("mid_rst_hdr_valid", 32'(hdr_valid), 32'(0));
    checkOutput("mid_rst_hdr_ncl",   32'(hdr_ncl),   32'(0));
    checkOutput("mid_rst_hdr_ovf",   32'(hdr_ovf),   32'(0));
    checkOutput("mid_rst_hdr_bxn",   32'(hdr_bxn),   32'(0));
    checkOutput("mid_rst_sel_valid", 32'(sel_valid), 32'(0));
    checkOutput("mid_rst_sel_idx",   32'(sel_idx),   32'(0));
    checkOutput("mid_rst_sel_last",  32'(sel_last),  32'(0));
    checkOutput("mid_rst_busy",      32'(busy),      32'(0));
    checkOutput("mid_rst_trunc",     32'(trunc_cnt), 32'(0));
    checkOutput("mid_rst_drop",      32'(drop_cnt),  32'(0));
    hdr_q.delete();
    sel_q.delete();
    model_bx    = 0;
    model_trunc = 0;
    model_drop  = 0;
    for (int i = 0; i < LAT; i++) dly_cnt[i] = 0;
    repeat (2) @(posedge clock4x);
    #1;
    reset_n   = 1'b1;
    sel_ready = 1'b1;
    repeat (5) applyStimulus(1'b0, 1'b0, 0, 1'b0);
    checkOutput("post_rst_drop", 32'(drop_cnt), 32'(0));
    checkOutput("post_rst_busy", 32'(busy),     32'(0));
    applyStimulus(1'b1, 1'b0, 3, 1'b0);
    drain(30);
    checkOutput("post_rst_bxn",   32'(hdr_bxn),   32'(0));
    checkOutput("post_rst_trunc", 32'(trunc_cnt), 32'(model_trunc));
    checkOutput("post_rst_drop2", 32'(drop_cnt),  32'(model_drop));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/cluster_frame_scheduler.md
Name: cluster_frame_scheduler

Overview:
Per-bunch-crossing scheduler sitting after the cluster-count tree. It aligns each frame's strobe with the pipelined cluster count and clamps that count to the output budget. It then emits a frame header and issues one slot-select per cluster to the downstream cluster encoder, using a valid/ready handshake. Truncation and dropped-frame statistics are kept for slow control.

Parameters:
MAX_CLUSTERS, 8, cluster slots readable per frame (>=2)
CNT_LATENCY, 2, clock4x cycles from frame_start (vpfs sampled) to cnt valid
CNT_W, 8, width of cnt input
BX_MAX, 3564, bunch-crossing counter modulus
STAT_W, 16, width of saturating statistics counters

Ports:
clock4x  in  1  single clock
reset_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse, vpfs of a new frame presented this cycle
bx0  in  1  coincident with frame_start: this frame is BX 0
cnt  in  CNT_W  cluster count from counter tree, valid CNT_LATENCY cycles after frame_start
hdr_valid  out  1  one-cycle header strobe
hdr_ncl  out  clog2(MAX_CLUSTERS+1)  clusters to be sent this frame
hdr_ovf  out  1  cnt exceeded MAX_CLUSTERS
hdr_bxn  out  12  frame BX number
sel_valid  out  1  slot select valid
sel_idx  out  clog2(MAX_CLUSTERS)  cluster slot index
sel_last  out  1  final select of frame
sel_ready  in  1  encoder accepts select
busy  out  1  FSM not IDLE or pending frame held
trunc_cnt  out  STAT_W  saturating count of clusters discarded by clamping
drop_cnt  out  STAT_W  saturating count of frames dropped

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM IDLE, alignment pipe and pending slot cleared, bxn=0. A reset mid-frame discards in-flight frames without counting them as drops.
- BX counter, at each frame_start:
  - bx0=1: frame tag 0, counter reloads to 1.
  - else: tag = counter, counter increments mod BX_MAX (BX_MAX-1 wraps to 0).
- Alignment: CNT_LATENCY-deep shift register of {valid, bxn}. At its output ("arrival", cycle t+CNT_LATENCY), sample cnt:
  - ncl = min(cnt, MAX_CLUSTERS)
  - ovf = cnt > MAX_CLUSTERS
  - trunc_cnt += cnt-ncl, saturating at all-ones
- FSM states IDLE, ISSUE.
  - IDLE + frame available: next cycle hdr_valid=1 with ncl/ovf/bxn.
    - Frame source: the pending slot has priority over a simultaneous arrival, and that arrival then fills pending.
    - ncl=0: header only, stay IDLE.
    - else enter ISSUE, with sel_valid=1 and sel_idx=0 in the same cycle as hdr_valid.
  - ISSUE: sel_valid held, sel_idx stable until sel_ready.
    - On handshake: idx increments.
    - sel_last=1 when idx=ncl-1.
    - Handshake on last: if pending valid, hdr_valid next cycle for pending (no bubble beyond 1 cycle); else IDLE with sel_valid=0 next cycle.
- Idle latency: frame_start at t -> hdr_valid at t+CNT_LATENCY+1.
- Arrival while ISSUE or pending occupied:
  - pending empty or being popped this cycle -> store in pending.
  - else frame discarded, drop_cnt += 1 saturating; trunc_cnt still updated for it.
- hdr_* fields hold last value when hdr_valid=0. sel_idx returns to 0 when sel_valid=0.
- frame_start spacing below CNT_LATENCY+1 is legal; the pipe handles back-to-back pulses.
- busy = (state != IDLE) | pending_valid.

Decomposition:
- Shared package: MAX_CLUSTERS, BX_MAX, CNT_LATENCY defaults, state encoding (IDLE=0, ISSUE=1), header field widths.
- One sub-module, sat_counter (STAT_W, increment amount input, saturate), instantiated twice for trunc_cnt and drop_cnt.

Test Plan:
- Reset, frame_start with cnt=5 at t+2, sel_ready=1 -> hdr_valid at t+3, ncl=5, ovf=0, bxn=0; sel_idx 0..4 on t+3..t+7, sel_last at t+7.
- cnt=12 -> ncl=8, ovf=1, 8 selects, trunc_cnt=4; repeat to drive trunc_cnt to 0xFFFF and confirm it holds.
- sel_ready low 3 cycles at idx=2 -> idx stays 2 with sel_valid high, resumes at 3; no dropped selects.
- Frames every 4 cycles, cnt=8, sel_ready=1 -> pending used, no drops. Same with sel_ready stuck low -> third frame dropped, drop_cnt=1.
- cnt=0 frame -> single hdr_valid with ncl=0, no sel_valid, FSM stays IDLE.
- BX wrap: 3564 frames -> bxn 3563 then 0. bx0 mid-count -> tag 0, next frame 1. reset_n low during ISSUE -> all outputs 0 immediately, drop_cnt unchanged at 0.
